// File: rtl/uart_rx_frame.sv
// UART receive engine: runtime data width, none/even/odd parity, 1 or 2 stop bits, break detection.
// Optional `UART_RX_MAJORITY_EN selects 2-of-3 voting on every sample instead of a single centre sample.
module uart_rx_frame #(
  parameter int DBIT_MAX = 9,
  parameter int OS_TICK  = 16
) (
  input  logic                clk,
  input  logic                rx_rst,
  input  logic                rx_en,
  input  logic                s_tick,
  input  logic                rx,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  output logic [DBIT_MAX-1:0] dout,
  output logic                rx_done_tick,
  output logic                rx_error_tick,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                rx_busy
);

  localparam int TW = $clog2(OS_TICK);
  localparam logic [TW-1:0] LAST = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] HALF = TW'(OS_TICK / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_reg, state_next;
  logic                rx_s1_reg, rx_s_reg;
  logic [TW-1:0]       tick_reg, tick_next;
  logic [3:0]          bit_idx_reg, bit_idx_next;
  logic [3:0]          dbits_reg, dbits_next;
  logic [DBIT_MAX-1:0] b_reg, b_next;
  logic                par_en_reg, par_en_next;
  logic                par_odd_reg, par_odd_next;
  logic                stop2_reg, stop2_next;
  logic                stop_cnt_reg, stop_cnt_next;
  logic                perr_acc_reg, perr_acc_next;
  logic                ferr_acc_reg, ferr_acc_next;
  logic                zero_reg, zero_next;
  logic                hold_reg, hold_next;
  logic [DBIT_MAX-1:0] dout_reg, dout_next;
  logic                perr_reg, perr_next;
  logic                ferr_reg, ferr_next;
  logic                brk_reg, brk_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic [TW-1:0]       pt;
  logic                sample;
  logic                ferr_v, brk_v;

  assign pt = (state_reg == START) ? HALF : LAST;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_reg, vote_next;
  assign sample = (vote_reg[0] & vote_reg[1]) | (vote_reg[0] & rx_s_reg) | (vote_reg[1] & rx_s_reg);
`else
  assign sample = rx_s_reg;
`endif

  always_ff @(posedge clk) begin
    if (rx_rst) begin
      rx_s1_reg    <= 1'b1;
      rx_s_reg     <= 1'b1;
      state_reg    <= IDLE;
      tick_reg     <= '0;
      bit_idx_reg  <= '0;
      dbits_reg    <= '0;
      b_reg        <= '0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      stop_cnt_reg <= 1'b0;
      perr_acc_reg <= 1'b0;
      ferr_acc_reg <= 1'b0;
      zero_reg     <= 1'b0;
      hold_reg     <= 1'b0;
      dout_reg     <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      brk_reg      <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      vote_reg     <= '0;
`endif
    end else begin
      rx_s1_reg    <= rx;
      rx_s_reg     <= rx_s1_reg;
      state_reg    <= state_next;
      tick_reg     <= tick_next;
      bit_idx_reg  <= bit_idx_next;
      dbits_reg    <= dbits_next;
      b_reg        <= b_next;
      par_en_reg   <= par_en_next;
      par_odd_reg  <= par_odd_next;
      stop2_reg    <= stop2_next;
      stop_cnt_reg <= stop_cnt_next;
      perr_acc_reg <= perr_acc_next;
      ferr_acc_reg <= ferr_acc_next;
      zero_reg     <= zero_next;
      hold_reg     <= hold_next;
      dout_reg     <= dout_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      brk_reg      <= brk_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
`ifdef UART_RX_MAJORITY_EN
      vote_reg     <= vote_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_next     = tick_reg;
    bit_idx_next  = bit_idx_reg;
    dbits_next    = dbits_reg;
    b_next        = b_reg;
    par_en_next   = par_en_reg;
    par_odd_next  = par_odd_reg;
    stop2_next    = stop2_reg;
    stop_cnt_next = stop_cnt_reg;
    perr_acc_next = perr_acc_reg;
    ferr_acc_next = ferr_acc_reg;
    zero_next     = zero_reg;
    hold_next     = hold_reg;
    dout_next     = dout_reg;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;
    brk_next      = brk_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    ferr_v        = 1'b0;
    brk_v         = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    vote_next     = vote_reg;
`endif

    if (state_reg == IDLE) begin
      // A frame that ended with the line low (break) must see the line high before re-arming.
      if (hold_reg && rx_s_reg)
        hold_next = 1'b0;
      if (rx_en && !rx_s_reg && !hold_reg) begin
        if (cfg_dbits < 4'd5)
          dbits_next = 4'd5;
        else if (cfg_dbits > 4'(DBIT_MAX))
          dbits_next = 4'(DBIT_MAX);
        else
          dbits_next = cfg_dbits;
        par_en_next   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        par_odd_next  = (cfg_parity == 2'b10);
        stop2_next    = cfg_stop2;
        tick_next     = '0;
        bit_idx_next  = '0;
        b_next        = '0;
        stop_cnt_next = 1'b0;
        perr_acc_next = 1'b0;
        ferr_acc_next = 1'b0;
        zero_next     = 1'b1;
        state_next    = START;
      end
    end else if (!rx_en) begin
      state_next = IDLE;
    end else if (s_tick) begin
      if (tick_reg != pt) begin
        tick_next = tick_reg + 1'b1;
`ifdef UART_RX_MAJORITY_EN
        if (tick_reg == pt - TW'(2)) vote_next[0] = rx_s_reg;
        if (tick_reg == pt - TW'(1)) vote_next[1] = rx_s_reg;
`endif
      end else begin
        tick_next = '0;
        case (state_reg)
          START: state_next = sample ? IDLE : DATA;
          DATA: begin
            b_next[bit_idx_reg] = sample;
            zero_next           = zero_reg & ~sample;
            bit_idx_next        = bit_idx_reg + 4'd1;
            if (bit_idx_reg == dbits_reg - 4'd1)
              state_next = par_en_reg ? PARITY : STOP;
          end
          PARITY: begin
            perr_acc_next = (^b_reg) ^ sample ^ par_odd_reg;
            zero_next     = zero_reg & ~sample;
            state_next    = STOP;
          end
          STOP: begin
            ferr_v        = ferr_acc_reg | ~sample;
            brk_v         = stop_cnt_reg ? zero_reg : (zero_reg & ~sample);
            ferr_acc_next = ferr_v;
            zero_next     = brk_v;
            if (stop2_reg && !stop_cnt_reg) begin
              stop_cnt_next = 1'b1;
            end else begin
              dout_next  = b_reg;
              perr_next  = perr_acc_reg;
              ferr_next  = ferr_v;
              brk_next   = brk_v;
              done_next  = 1'b1;
              err_next   = perr_acc_reg | ferr_v;
              hold_next  = ~sample;
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  assign dout          = dout_reg;
  assign rx_done_tick  = done_reg;
  assign rx_error_tick = err_reg;
  assign parity_err    = perr_reg;
  assign frame_err     = ferr_reg;
  assign break_det     = brk_reg;
  assign rx_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: s_tick every 4 clk, 16 ticks per bit, so one bit = 64 clk.
module tb_uart_rx_frame;
  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rx_rst = 1'b1;
  logic       rx_en = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] cfg_dbits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic [8:0] dout;
  logic       rx_done_tick, rx_error_tick, parity_err, frame_err, break_det, rx_busy;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int lone_err = 0;
  int busy_cnt = 0;
  logic [1:0] tdiv = 2'd0;

  uart_rx_frame #(.DBIT_MAX(9), .OS_TICK(16)) dut (
    .clk(clk), .rx_rst(rx_rst), .rx_en(rx_en), .s_tick(s_tick), .rx(rx),
    .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .dout(dout), .rx_done_tick(rx_done_tick), .rx_error_tick(rx_error_tick),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv   <= tdiv + 2'd1;
    s_tick <= (tdiv == 2'd3);
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      if (rx_error_tick) err_cnt++;
    end
    if (rx_error_tick && !rx_done_tick) lone_err++;
    if (rx_busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v[i];
      wait_clk(BIT_CLK);
    end
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
  endtask

  task automatic chk_frame(input string tag, input logic [8:0] e_dout, input logic e_p,
                           input logic e_f, input logic e_b, input int d0, input int e0,
                           input int e_done, input int e_err);
    $display("frame %s: dout=%03h perr=%0b ferr=%0b brk=%0b", tag, dout, parity_err, frame_err, break_det);
    chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
    chk({tag, ".parity_err"}, 32'(parity_err), 32'(e_p));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(e_f));
    chk({tag, ".break_det"}, 32'(break_det), 32'(e_b));
    chk({tag, ".done"}, 32'(done_cnt - d0), 32'(e_done));
    chk({tag, ".err_tick"}, 32'(err_cnt - e0), 32'(e_err));
  endtask

  initial begin
    int d0, e0, b0;
    logic [15:0] v;

    wait_clk(4);
    chk("reset.dout", 32'(dout), 32'h0);
    chk("reset.flags", 32'({parity_err, frame_err, break_det}), 32'h0);
    chk("reset.busy", 32'(rx_busy), 32'h0);
    rx_rst = 1'b0;
    wait_clk(BIT_CLK);

    // 8N1 0x55, with start-detect latency measured on the falling edge
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    wait_clk(2);
    chk("latency.2clk", 32'(rx_busy), 32'h0);
    wait_clk(1);
    chk("latency.3clk", 32'(rx_busy), 32'h1);
    wait_clk(BIT_CLK - 3);
    v = {7'h0, 1'b1, 8'h55};
    send_bits(v, 9);
    chk_frame("8N1", 9'h055, 1'b0, 1'b0, 1'b0, d0, e0, 1, 0);

    // 7E1 0x3A (four ones), correct parity 0 then wrong parity 1
    cfg_dbits = 4'd7; cfg_parity = 2'b01;
    d0 = done_cnt; e0 = err_cnt;
    v = {6'h0, 1'b1, 1'b0, 7'h3A, 1'b0};
    send_bits(v, 10);
    chk_frame("7E1ok", 9'h03A, 1'b0, 1'b0, 1'b0, d0, e0, 1, 0);
    d0 = done_cnt; e0 = err_cnt;
    v = {6'h0, 1'b1, 1'b1, 7'h3A, 1'b0};
    send_bits(v, 10);
    chk_frame("7E1bad", 9'h03A, 1'b1, 1'b0, 1'b0, d0, e0, 1, 1);

    // 9O2 0x1A5 (five ones, parity bit 0 is correct), second stop bit low
    cfg_dbits = 4'd9; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    v = {3'h0, 1'b0, 1'b1, 1'b0, 9'h1A5, 1'b0};
    send_bits(v, 13);
    chk_frame("9O2", 9'h1A5, 1'b0, 1'b1, 1'b0, d0, e0, 1, 1);

    // Break on 8N1: 12 bit periods low gives exactly one frame
    cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    wait_clk(12 * BIT_CLK);
    send_bits(16'hFFFF, 1);
    chk_frame("break", 9'h000, 1'b0, 1'b1, 1'b1, d0, e0, 1, 1);

    // Glitch: low for 4 s_tick periods
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("glitch.busy_seen", 32'(busy_cnt > b0), 32'h1);
    chk("glitch.busy_now", 32'(rx_busy), 32'h0);
    chk_frame("glitch", 9'h000, 1'b0, 1'b1, 1'b1, d0, e0, 0, 0);

    // Reset during DATA of 0xC3, then a clean 0xF1
    d0 = done_cnt; e0 = err_cnt;
    v = {7'h0, 1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      wait_clk(BIT_CLK);
    end
    wait_clk(BIT_CLK / 2);
    chk("rst.busy_before", 32'(rx_busy), 32'h1);
    rx_rst = 1'b1;
    rx = 1'b1;
    wait_clk(1);
    rx_rst = 1'b0;
    chk("rst.outputs", 32'({dout, rx_done_tick, rx_error_tick, parity_err, frame_err, break_det, rx_busy}), 32'h0);
    wait_clk(2 * BIT_CLK);
    chk("rst.no_done", 32'(done_cnt - d0), 32'h0);
    v = {7'h0, 1'b1, 8'hF1, 1'b0};
    send_bits(v, 10);
    chk_frame("after_rst", 9'h0F1, 1'b0, 1'b0, 1'b0, d0, e0, 1, 0);

    // rx_en dropped mid-frame
    d0 = done_cnt; e0 = err_cnt;
    v = {7'h0, 1'b1, 8'h0F, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = v[i];
      wait_clk(BIT_CLK);
    end
    rx_en = 1'b0;
    wait_clk(4);
    chk("en_abort.busy", 32'(rx_busy), 32'h0);
    rx = 1'b1;
    wait_clk(4);
    rx_en = 1'b1;
    wait_clk(12 * BIT_CLK);
    chk_frame("en_abort", 9'h0F1, 1'b0, 1'b0, 1'b0, d0, e0, 0, 0);

    chk("error_tick_alone", 32'(lone_err), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive engine, successor to the fixed-format 8N1 receiver in the UART IP datapath. It runs off the shared baud generator's `s_tick`, an oversampling enable. The data width is set per frame by a runtime configuration that is latched at each start bit. Parity is selectable as none, even or odd, with one or two stop bits. Parity, framing and break errors are reported as separate flags, and a glitch filter rejects false starts.

## Interface
- `DBIT_MAX`, 9 — widest supported data field; `dout` width.
- `OS_TICK`, 16 — `s_tick` pulses per bit; must be even and ≥ 8.
- `clk`  in  1  — system clock.
- `rx_rst`  in  1  — synchronous, active-high reset; every register is cleared on the `clk` edge where it is high.
- `rx_en`  in  1  — receiver enable.
- `s_tick`  in  1  — oversample strobe, one `clk` wide.
- `rx`  in  1  — serial line, asynchronous; idles high.
- `cfg_dbits`  in  4  — data bits per frame; 5..`DBIT_MAX`.
- `cfg_parity`  in  2  — 00 none, 01 even, 10 odd, 11 treated as none.
- `cfg_stop2`  in  1  — 1 selects two stop bits.
- `dout`  out  `DBIT_MAX`  — received data, LSB-first assembled, right-aligned; unused upper bits are 0.
- `rx_done_tick`  out  1  — one-`clk` pulse per completed frame.
- `rx_error_tick`  out  1  — one-`clk` pulse, coincident with `rx_done_tick`, when `parity_err` or `frame_err` is set.
- `parity_err`, `frame_err`, `break_det`  out  1 each — status of the last completed frame.
- `rx_busy`  out  1  — high in every state except IDLE.

## Operation
- **Input synchronizer.** `rx` passes through a 2-FF synchronizer that resets to 1. All sampling uses the synchronized value `rx_s`.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE.** When `rx_en`=1 and `rx_s`=0, latch `cfg_*`, clear the tick counter and go to START.
  - `cfg_dbits` < 5 is treated as 5.
  - `cfg_dbits` > `DBIT_MAX` is treated as `DBIT_MAX`.
- **START.** Count `s_tick` pulses.
  - At count `OS_TICK`/2−1, if the sample is 0, clear the counter and go to DATA.
  - Otherwise go to IDLE (false start). No flags change.
- **DATA.** On the `s_tick` where the counter equals `OS_TICK`−1:
  - write the sample into `b_reg[bit_idx]`;
  - increment `bit_idx`;
  - after bit `dbits`−1, go to PARITY if parity is enabled, else to STOP.
- **PARITY.** Sample at `OS_TICK`−1.
  - Even mode: error if XOR(data, parity bit) = 1.
  - Odd mode: error if it is 0.
- **STOP.** Sample at `OS_TICK`−1.
  - A 0 sample sets the frame error.
  - With `cfg_stop2`, count a second bit period and sample it the same way.
  - After the last stop sample, return to IDLE immediately. Back-to-back frames resynchronize within half a stop bit.
- **Frame completion.** `dout`, `parity_err`, `frame_err` and `break_det` are updated and `rx_done_tick` pulses in the same cycle. The status flags hold until the next completion.
  - `break_det` = all data bits 0, parity bit 0 (if present) and first stop bit 0.
  - A break always implies `frame_err`.
- **`rx_en` deasserted mid-frame.** Abort to IDLE with no done tick; outputs keep their previous values.
- **Configuration changes mid-frame.** Ignored; the values latched at the start bit apply to the whole frame.

## Timing
- **Reset values:** `dout`=0, all flags and ticks 0, `rx_busy`=0, state IDLE, synchronizer stages = 1.
- **Start detection:** `rx` falling edge to `rx_busy` high takes 3 `clk` (2 synchronizer stages + 1 state register), independent of `s_tick`.
- **Bit sampling:** each bit is sampled `OS_TICK` ticks after the previous sample. The start bit is sampled at mid-bit, so all later samples land at bit centres.
- **Frame completion:** `rx_done_tick` is asserted on the `clk` after the `s_tick` that takes the final stop sample. That point is (1 + dbits + parity + stop bits − 0.5) bit periods after the start edge.
- **Simultaneous events:** `rx_rst` wins over everything. An `s_tick` in the same cycle as `rx_rst` is ignored.
- **Tick counter width:** clog2(`OS_TICK`); wraps to 0 at each bit boundary.

## Configuration
- **Macro:** `UART_RX_MAJORITY_EN`.
- **Defined:** every data, parity and stop sample is the 2-of-3 majority of `rx_s` at counts `OS_TICK`−3, `OS_TICK`−2 and `OS_TICK`−1. The decision is made at `OS_TICK`−1. The START check uses counts `OS_TICK`/2−3 to `OS_TICK`/2−1. A single-tick glitch inside the window is rejected.
- **Undefined:** a single sample at `OS_TICK`−1 (START: `OS_TICK`/2−1). The vote registers are removed.

## Test plan
- **8N1:** `cfg_dbits`=8, parity none, one stop bit, send 0x55 → `dout`=0x055, one `rx_done_tick`, all error flags 0.
- **7E1:** `cfg_dbits`=7, even parity, send 0x3A with parity bit 0 → `dout`=0x03A, `parity_err`=0. Repeat with parity bit 1 → `parity_err`=1 and `rx_error_tick` coincident with `rx_done_tick`.
- **9O2:** `cfg_dbits`=9, odd parity, `cfg_stop2`=1, send 0x1A5 with the second stop bit driven 0 → `dout`=0x1A5, `frame_err`=1, `parity_err`=0.
- **Break:** 8N1, hold `rx` low for 12 bit periods → `dout`=0x00, `frame_err`=1, `break_det`=1. No second frame until `rx` returns high and falls again.
- **Glitch:** drive `rx` low for 4 `s_tick` then high → `rx_busy` pulses then clears, no `rx_done_tick`, flags unchanged.
- **Reset and enable mid-frame:**
  - Pulse `rx_rst` during DATA of a 0xC3 frame → all outputs 0 on the next `clk`, no done tick. The next full frame 0xF1 is received correctly.
  - Drop `rx_en` mid-frame → abort with no done tick.
